// File: rtl/uart_rx_fifo_if.sv
// Byte-stream interface between a UART receiver, the RX FIFO and its consumer.
// The slave modport is the FIFO side; the master modport is the receiver/consumer side.
interface uart_rx_fifo_if #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic          uart_rx_valid;
    logic [7:0]    uart_rx_data;
    logic          uart_rx_break;
    logic          rd_valid;
    logic          rd_ready;
    logic [7:0]    rd_data;
    logic [CW-1:0] fill_level;
    logic          overflow;
    logic          flag_clear;
    logic          break_seen;

    modport slave (
        input  uart_rx_valid, uart_rx_data, uart_rx_break, rd_ready, flag_clear,
        output rd_valid, rd_data, fill_level, overflow, break_seen
    );

    modport master (
        output uart_rx_valid, uart_rx_data, uart_rx_break, rd_ready, flag_clear,
        input  rd_valid, rd_data, fill_level, overflow, break_seen
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word fall-through byte FIFO behind a UART receiver, with sticky overflow/break flags.
// Optional macro UART_RX_FIFO_BREAK_FLUSH_EN: a break pulse flushes the FIFO and sets break_seen.
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    uart_rx_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fill_q, fill_d;
    logic          rd_valid_q;
    logic          ovf_q, ovf_d;
    logic          push, pop, drop, flush;

`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
    logic          brk_q, brk_d;
`else
    logic          unused_break;
    assign unused_break = bus.uart_rx_break;
`endif

    always_comb begin
        flush = 1'b0;
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
        flush = bus.uart_rx_break;
`endif
        pop  = rd_valid_q & bus.rd_ready;
        // A full FIFO still accepts a byte when a pop frees a slot on the same edge.
        push = bus.uart_rx_valid & ((fill_q != CW'(DEPTH)) | pop) & ~flush;
        drop = bus.uart_rx_valid & ~push & ~flush;

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + CW'(1);
            2'b01:   fill_d = fill_q - CW'(1);
            default: fill_d = fill_q;
        endcase
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end

        // Set events win over a simultaneous clear.
        ovf_d = drop ? 1'b1 : (bus.flag_clear ? 1'b0 : ovf_q);
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
        brk_d = flush ? 1'b1 : (bus.flag_clear ? 1'b0 : brk_q);
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fill_q     <= '0;
            rd_valid_q <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
            brk_q      <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fill_q     <= fill_d;
            rd_valid_q <= (fill_d != '0);
            ovf_q      <= ovf_d;
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
            brk_q      <= brk_d;
`endif
        end
    end

    // Storage carries no reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.uart_rx_data;
    end

    assign bus.rd_valid   = rd_valid_q;
    assign bus.rd_data    = rd_valid_q ? mem_q[rd_ptr_q] : 8'h00;
    assign bus.fill_level = fill_q;
    assign bus.overflow   = ovf_q;
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
    assign bus.break_seen = brk_q;
`else
    assign bus.break_seen = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: queue-based reference model compared every cycle,
// plus directed literal checks and a randomized push/pop/flag run.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_rx_fifo_if #(.DEPTH(DEPTH), .CW(CW)) bus ();

    uart_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Reference model: a byte queue and two sticky bits.
    logic [7:0] mq[$];
    bit         m_ovf = 1'b0;
    bit         m_brk = 1'b0;

    always @(posedge clk) begin
        bit do_pop, brk_ev, dropped;
        if (reset) begin
            mq.delete();
            m_ovf = 1'b0;
            m_brk = 1'b0;
        end else begin
            brk_ev = 1'b0;
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
            brk_ev = bus.uart_rx_break;
`endif
            dropped = 1'b0;
            if (brk_ev) begin
                mq.delete();
            end else begin
                do_pop = (mq.size() > 0) && bus.rd_ready;
                if (do_pop) void'(mq.pop_front());
                if (bus.uart_rx_valid) begin
                    if (mq.size() < DEPTH) mq.push_back(bus.uart_rx_data);
                    else dropped = 1'b1;
                end
            end
            m_ovf = dropped ? 1'b1 : (bus.flag_clear ? 1'b0 : m_ovf);
            m_brk = brk_ev  ? 1'b1 : (bus.flag_clear ? 1'b0 : m_brk);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if (bus.fill_level !== CW'(mq.size()) || bus.rd_valid !== (mq.size() > 0) ||
                bus.overflow !== m_ovf || bus.break_seen !== m_brk ||
                (mq.size() > 0 && bus.rd_data !== mq[0])) begin
                n_bad++;
                $display("FAIL model t=%0t: fill=%0d valid=%0b data=%02h ovf=%0b brk=%0b, expected fill=%0d valid=%0b data=%02h ovf=%0b brk=%0b",
                         $time, bus.fill_level, bus.rd_valid, bus.rd_data, bus.overflow, bus.break_seen,
                         mq.size(), mq.size() > 0, (mq.size() > 0) ? mq[0] : 8'h00, m_ovf, m_brk);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [7:0] d, input bit brk, input bit rdy, input bit fc);
        bus.uart_rx_valid = v;
        bus.uart_rx_data  = d;
        bus.uart_rx_break = brk;
        bus.rd_ready      = rdy;
        bus.flag_clear    = fc;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        drive(0, 8'h00, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_fill"},  32'(bus.fill_level), 0);
        chk({tag, "_valid"}, 32'(bus.rd_valid),   0);
        chk({tag, "_data"},  32'(bus.rd_data),    0);
        chk({tag, "_ovf"},   32'(bus.overflow),   0);
        chk({tag, "_brk"},   32'(bus.break_seen), 0);
    endtask

    task automatic drain(input int n, output logic [7:0] last);
        last = 8'h00;
        for (int i = 0; i < n; i++) begin
            last = bus.rd_data;
            drive(0, 8'h00, 0, 1, 0);
            tick();
        end
        idle();
    endtask

    initial begin
        logic [7:0] last;
        int guard;
        reset = 1'b1;
        idle();
        tick(); tick();
        chk_en = 1'b1;
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        // Single byte through, then popped.
        drive(1, 8'hAA, 0, 0, 0); tick(); idle();
        chk("aa_valid", 32'(bus.rd_valid), 1);
        chk("aa_data",  32'(bus.rd_data), 32'hAA);
        chk("aa_fill",  32'(bus.fill_level), 1);
        drive(0, 8'h00, 0, 1, 0); tick(); idle();
        chk("aa_pop_fill",  32'(bus.fill_level), 0);
        chk("aa_pop_valid", 32'(bus.rd_valid), 0);

        // Fill to capacity, then overflow.
        for (int i = 0; i < DEPTH; i++) begin drive(1, 8'(i), 0, 0, 0); tick(); end
        drive(1, 8'h55, 0, 0, 0); tick(); idle();
        chk("full_fill", 32'(bus.fill_level), 16);
        chk("full_ovf",  32'(bus.overflow), 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk("drain_order", 32'(bus.rd_data), 32'(i));
            drive(0, 8'h00, 0, 1, 0); tick();
        end
        idle();
        chk("drained_fill", 32'(bus.fill_level), 0);
        chk("ovf_sticky",   32'(bus.overflow), 1);
        drive(0, 8'h00, 0, 0, 1); tick(); idle();
        chk("ovf_clear", 32'(bus.overflow), 0);

        // Full with simultaneous pop accepts the byte.
        for (int i = 0; i < DEPTH; i++) begin drive(1, 8'(8'h10 + i), 0, 0, 0); tick(); end
        drive(1, 8'h77, 0, 1, 0); tick(); idle();
        chk("fullpop_fill", 32'(bus.fill_level), 16);
        chk("fullpop_ovf",  32'(bus.overflow), 0);
        chk("fullpop_head", 32'(bus.rd_data), 32'h11);
        drain(DEPTH, last);
        chk("fullpop_last", 32'(last), 32'h77);

        // Break handling with 5 bytes stored.
        for (int i = 0; i < 5; i++) begin drive(1, 8'(8'hC0 + i), 0, 0, 0); tick(); end
`ifdef UART_RX_FIFO_BREAK_FLUSH_EN
        drive(1, 8'hEE, 1, 0, 0); tick(); idle();
        chk("brk_fill",  32'(bus.fill_level), 0);
        chk("brk_valid", 32'(bus.rd_valid), 0);
        chk("brk_seen",  32'(bus.break_seen), 1);
        chk("brk_ovf",   32'(bus.overflow), 0);
        drive(0, 8'h00, 0, 0, 1); tick(); idle();
        chk("brk_clear", 32'(bus.break_seen), 0);
`else
        drive(0, 8'h00, 1, 0, 0); tick(); idle();
        chk("nobrk_fill", 32'(bus.fill_level), 5);
        chk("nobrk_head", 32'(bus.rd_data), 32'hC0);
        chk("nobrk_seen", 32'(bus.break_seen), 0);
        drain(5, last);
        chk("nobrk_last", 32'(last), 32'hC4);
`endif

        // Randomized traffic; the per-cycle model compare does the checking.
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 2,
                  $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 5);
            tick();
        end
        idle();
        guard = 0;
        while (bus.rd_valid && guard < 4 * DEPTH) begin
            drive(0, 8'h00, 0, 1, 0); tick(); guard++;
        end
        idle();
        chk("final_empty", 32'(bus.rd_valid), 0);

        // Reset mid-stream discards stored bytes and sticky flags.
        for (int i = 0; i < 3; i++) begin drive(1, 8'(8'h30 + i), 0, 0, 0); tick(); end
        idle();
        chk("pre_reset_fill", 32'(bus.fill_level), 3);
        reset = 1'b1;
        drive(1, 8'h99, 1, 1, 1);
        tick();
        reset = 1'b0;
        idle();
        check_reset_outputs("midreset");
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
